// File: rtl/boa_arb_pkg.sv
// Shared types and owner encodings for the program/data memory arbiter.
package boa_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD_P,
        ARB_HOLD_D
    } boa_arb_state_t;

    localparam logic [1:0] ARB_OWN_NONE = 2'b00;
    localparam logic [1:0] ARB_OWN_P    = 2'b01;
    localparam logic [1:0] ARB_OWN_D    = 2'b10;

endpackage

// File: rtl/boa_mem_arbiter.sv
// Shares one memory port between the instruction-fetch and data buses.
// Data has priority, bounded by a starvation counter; a started transfer stays locked until m_ready.
module boa_mem_arbiter
    import boa_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_re,
    input  logic [31:2] p_addr,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    input  logic        d_re,
    input  logic [3:0]  d_we,
    input  logic [31:2] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_re,
    output logic [3:0]  m_we,
    output logic [31:2] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic [1:0]  q_owner
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    boa_arb_state_t state_reg, state_next;
    logic [3:0]     starve_reg, starve_next;
    logic [1:0]     winner;
    logic           p_req, d_req;

    assign p_req = p_re;
    assign d_req = d_re | (|d_we);

    // Reset gates the winner combinationally so the memory side is quiet
    // the instant rst_n falls, even with requests still asserted.
    always_comb begin
        winner = ARB_OWN_NONE;
        if (rst_n) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (d_req && (starve_reg < STARVE_LIM)) winner = ARB_OWN_D;
                    else if (p_req)                         winner = ARB_OWN_P;
                    else if (d_req)                         winner = ARB_OWN_D;
                end
                ARB_HOLD_P: winner = ARB_OWN_P;
                ARB_HOLD_D: winner = ARB_OWN_D;
                default:    winner = ARB_OWN_NONE;
            endcase
        end
    end

    always_comb begin
        m_re    = 1'b0;
        m_we    = 4'h0;
        m_addr  = '0;
        m_wdata = 32'h0;
        if (winner == ARB_OWN_D) begin
            m_re    = d_re;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (winner == ARB_OWN_P) begin
            m_re    = p_re;
            m_addr  = p_addr;
        end
    end

    assign p_ready = m_ready & (winner == ARB_OWN_P);
    assign d_ready = m_ready & (winner == ARB_OWN_D);
    assign p_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign q_owner = winner;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                // A zero-wait completion in the grant cycle takes no lock.
                if (!m_ready) begin
                    if (winner == ARB_OWN_D)      state_next = ARB_HOLD_D;
                    else if (winner == ARB_OWN_P) state_next = ARB_HOLD_P;
                end
            end
            ARB_HOLD_P, ARB_HOLD_D: begin
                if (m_ready) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        starve_next = starve_reg;
        if (!p_req || p_ready) begin
            starve_next = 4'd0;
        end else if (d_ready && (starve_reg != 4'hF)) begin
            starve_next = starve_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ARB_IDLE;
            starve_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed bench for boa_mem_arbiter: single write, contention, lock hold,
// starvation clear and asynchronous reset during a held data transfer.
module tb_boa_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_re;
    logic [31:2] p_addr;
    logic [31:0] p_rdata;
    logic        p_ready;
    logic        d_re;
    logic [3:0]  d_we;
    logic [31:2] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_re;
    logic [3:0]  m_we;
    logic [31:2] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic [1:0]  q_owner;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    boa_mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p_re    (p_re),
        .p_addr  (p_addr),
        .p_rdata (p_rdata),
        .p_ready (p_ready),
        .d_re    (d_re),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_re    (m_re),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .q_owner (q_owner)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Contended zero-wait grants, one expected owner per cycle.
    task automatic run_grants(input string tag, input int n, input logic [15:0] pattern_d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_g%0d", tag, i), 64'(q_owner), pattern_d[i] ? 64'h2 : 64'h1);
            next_cycle();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        p_re    = 1'b1;
        p_addr  = 30'h0;
        d_re    = 1'b1;
        d_we    = 4'h0;
        d_addr  = 30'h0;
        d_wdata = 32'h0;
        m_rdata = 32'h1234_5678;
        m_ready = 1'b1;

        // Reset holds the memory side idle despite live requests.
        @(negedge clk);
        chk("rst_m_re", 64'(m_re), 64'h0);
        chk("rst_m_we", 64'(m_we), 64'h0);
        chk("rst_owner", 64'(q_owner), 64'h0);
        chk("rst_p_ready", 64'(p_ready), 64'h0);
        chk("rst_d_ready", 64'(d_ready), 64'h0);
        chk("rdata_bcast", {p_rdata, d_rdata}, 64'h1234_5678_1234_5678);
        next_cycle();
        rst_n = 1'b1;
        p_re  = 1'b0;
        d_re  = 1'b0;
        next_cycle();

        // Single data write with two wait states.
        d_we    = 4'hF;
        d_addr  = 30'h100;
        d_wdata = 32'hDEAD_BEEF;
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) m_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("wr_addr_c%0d", c), 64'(m_addr), 64'h100);
            chk($sformatf("wr_we_c%0d", c), 64'(m_we), 64'hF);
            chk($sformatf("wr_wdata_c%0d", c), 64'(m_wdata), 64'hDEAD_BEEF);
            chk($sformatf("wr_owner_c%0d", c), 64'(q_owner), 64'h2);
            chk($sformatf("wr_d_ready_c%0d", c), 64'(d_ready), (c == 2) ? 64'h1 : 64'h0);
            chk($sformatf("wr_p_ready_c%0d", c), 64'(p_ready), 64'h0);
            next_cycle();
        end
        d_we = 4'h0;
        @(negedge clk);
        chk("wr_after_owner", 64'(q_owner), 64'h0);
        chk("wr_after_m_we", 64'(m_we), 64'h0);
        next_cycle();

        // Contention with zero-wait memory: D D D D P D D D D P (bit i = 1 for D).
        p_re    = 1'b1;
        d_re    = 1'b1;
        p_addr  = 30'h40;
        d_addr  = 30'h80;
        m_ready = 1'b1;
        run_grants("cont", 10, 16'b01_1110_1111);
        p_re = 1'b0;
        d_re = 1'b0;
        next_cycle();

        // Lock hold: program starts, data arrives one cycle later.
        p_re    = 1'b1;
        p_addr  = 30'h200;
        m_ready = 1'b0;
        @(negedge clk);
        chk("lock_owner_c0", 64'(q_owner), 64'h1);
        chk("lock_addr_c0", 64'(m_addr), 64'h200);
        next_cycle();
        d_re   = 1'b1;
        d_addr = 30'h300;
        for (int c = 1; c < 4; c++) begin
            if (c == 3) m_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("lock_addr_c%0d", c), 64'(m_addr), 64'h200);
            chk($sformatf("lock_d_ready_c%0d", c), 64'(d_ready), 64'h0);
            chk($sformatf("lock_p_ready_c%0d", c), 64'(p_ready), (c == 3) ? 64'h1 : 64'h0);
            next_cycle();
        end
        p_re = 1'b0;
        @(negedge clk);
        chk("lock_next_owner", 64'(q_owner), 64'h2);
        chk("lock_next_addr", 64'(m_addr), 64'h300);
        chk("lock_next_d_ready", 64'(d_ready), 64'h1);
        next_cycle();
        d_re = 1'b0;
        next_cycle();

        // Starvation clear: three data grants, one cycle without p_re, then contention.
        p_re = 1'b1;
        d_re = 1'b1;
        run_grants("sc_pre", 3, 16'b111);
        p_re = 1'b0;
        @(negedge clk);
        chk("sc_gap_owner", 64'(q_owner), 64'h2);
        next_cycle();
        p_re = 1'b1;
        run_grants("sc_post", 5, 16'b0_1111);
        p_re = 1'b0;
        d_re = 1'b0;
        next_cycle();

        // Asynchronous reset while locked to the data bus.
        d_we    = 4'h3;
        d_addr  = 30'h55;
        m_ready = 1'b0;
        @(negedge clk);
        chk("ar_owner_pre", 64'(q_owner), 64'h2);
        next_cycle();
        p_re    = 1'b1;
        p_addr  = 30'h77;
        m_ready = 1'b1;
        #1;
        chk("ar_hold_owner", 64'(q_owner), 64'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_m_we", 64'(m_we), 64'h0);
        chk("ar_m_re", 64'(m_re), 64'h0);
        chk("ar_owner", 64'(q_owner), 64'h0);
        chk("ar_d_ready", 64'(d_ready), 64'h0);
        d_we    = 4'h0;
        m_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_post_owner", 64'(q_owner), 64'h1);
        chk("ar_post_m_re", 64'(m_re), 64'h1);
        chk("ar_post_addr", 64'(m_addr), 64'h77);
        chk("ar_post_m_we", 64'(m_we), 64'h0);
        next_cycle();
        p_re = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/boa_mem_arbiter.md
# boa_mem_arbiter

Two-port arbiter that shares a single memory port between the IF program bus and the MEM-stage data bus. Used on single-port memory configurations where the CPU core's program and data accesses must share one RAM or bridge. Data accesses have priority. A starvation counter guarantees instruction fetch forward progress. Once a transfer has started, the grant stays locked to that requester until the memory reports completion.

## Interface
- `STARVE_MAX`, default 4: consecutive data grants allowed while a program request is pending; range 1..15.
- `clk` in 1: CPU clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `p_re` in 1: program bus read request.
- `p_addr` in 30 [31:2]: program word address.
- `p_rdata` out 32: program read data. Broadcast of `m_rdata`.
- `p_ready` out 1: program transfer complete.
- `d_re` in 1: data bus read request.
- `d_we` in 4: data bus byte write enables.
- `d_addr` in 30 [31:2]: data word address.
- `d_wdata` in 32: data write data.
- `d_rdata` out 32: data read data. Broadcast of `m_rdata`.
- `d_ready` out 1: data transfer complete.
- `m_re` out 1: memory read request.
- `m_we` out 4: memory byte write enables.
- `m_addr` out 30 [31:2]: memory word address.
- `m_wdata` out 32: memory write data.
- `m_rdata` in 32: memory read data.
- `m_ready` in 1: memory transfer complete. Qualifies `m_rdata`.
- `q_owner` out 2: current owner, one-hot {data, program}; 0 when idle.

## Operation
- Request definitions:
  - `p_req = p_re`.
  - `d_req = d_re | (|d_we)`.
- States:
  - IDLE: no locked owner.
  - HOLD_P: locked to the program bus.
  - HOLD_D: locked to the data bus.
- Winner selection in IDLE (combinational, from the current request inputs):
  - Data wins if `d_req` and `starve < STARVE_MAX`.
  - Otherwise program wins if `p_req`.
  - Otherwise data wins if `d_req`.
  - Otherwise there is no winner.
- Winner selection in HOLD_x: the winner is the locked owner, regardless of its request lines.
- Memory-side drive:
  - `m_*` is muxed from the winner.
  - The program bus drives `m_we = 0` and `m_wdata = 0`.
  - With no winner, `m_re = 0` and `m_we = 0`.
  - `m_addr` and `m_wdata` are don't-care when there is no winner; the RTL drives 0.
- Ready routing: `x_ready = m_ready & (winner == x)`. The non-winner always sees ready 0.
- State transitions:
  - IDLE with a winner and `!m_ready`: go to HOLD_winner.
  - IDLE with a winner and `m_ready`: the transfer completes in the same cycle; stay in IDLE.
  - HOLD_x with `m_ready`: go to IDLE.
- Starvation counter `starve` (4 bits):
  - On a completed data transfer while `p_req` is high: saturating increment.
  - On a completed program transfer: clear.
  - On a cycle with `!p_req`: clear.
- Requester rules:
  - Requesters hold address, data and enables stable until their ready.
  - A requester dropping its request inside HOLD does not release the lock; the lock releases only on `m_ready`.
- Both `p_rdata` and `d_rdata` equal `m_rdata` unconditionally.

## Timing
- Arbitration adds zero cycles: a request in IDLE reaches `m_*` in the same cycle.
- Zero-wait memory (`m_ready` always 1) gives one transfer per cycle, with no idle cycle between owners.
- State and `starve` update on `posedge clk`.
- Simultaneous `p_req` and `d_req` in IDLE:
  - Data wins until `starve == STARVE_MAX`.
  - Then program wins exactly one transfer, and `starve` clears.
- `m_ready` arriving in the same cycle as a new request in IDLE completes that request. No lock is taken.
- Reset (`rst_n` low, asynchronous):
  - Effects: state goes to IDLE; `starve` clears to 0.
  - Forced outputs: `m_re = 0`, `m_we = 0`, `p_ready = 0`, `d_ready = 0`, `q_owner = 0`.
  - Scope: forced both during reset and when reset is asserted mid-HOLD. The in-flight transfer is abandoned.
- After reset release, arbitration resumes in the next cycle from IDLE.

## Structure
- Package `boa_arb_pkg`:
  - `typedef enum logic[1:0] {ARB_IDLE, ARB_HOLD_P, ARB_HOLD_D} boa_arb_state_t`.
  - Owner one-hot constants `ARB_OWN_P = 2'b01` and `ARB_OWN_D = 2'b10`.
- No sub-module: the winner mux, FSM and counter live in one file.

## Test plan
- Single data write:
  - Stimulus: `d_we = 4'hF`, `d_addr = 30'h100`, `d_wdata = 32'hDEADBEEF`; `m_ready` low for 2 cycles, then high.
  - Response: `m_*` mirror the data bus for 3 cycles; `q_owner = 2'b10`; `d_ready` pulses once in cycle 3; `p_ready` stays 0.
- Contention, zero-wait memory, `STARVE_MAX = 4`:
  - Stimulus: `p_re` and `d_re` held high for 10 cycles.
  - Response: grants follow D, D, D, D, P, D, D, D, D, P.
- Lock hold:
  - Stimulus: program read starts with `m_ready = 0`; `d_re` rises 1 cycle later.
  - Response: `m_addr` stays equal to `p_addr` until `m_ready`; `d_ready = 0` throughout; data is granted in the cycle after completion.
- Starvation clear:
  - Stimulus: 3 data grants with `p_re` high; `p_re` drops 1 cycle, then rises.
  - Response: `starve` is 0; the next 4 contended grants go to data.
- Async reset in HOLD_D:
  - Stimulus: `rst_n` low mid-cycle.
  - Response: `m_we = 0`, `m_re = 0` and `q_owner = 0` immediately; after release, a pending program request is granted in IDLE.
